// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the decode-to-execute issue stage.
//   - op_idx_e : bit positions of the one-hot op_en vector
//   - RV32I opcode / funct3 / funct7 encodings used by the decoder
//   - issue_t  : one decoded entry, held in both the main and skid registers
package ex_pkg;

    localparam int XLEN    = 32;
    localparam int NUM_OPS = 13;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_EQ   = 4'd10,
        OP_GE   = 4'd11,
        OP_GEU  = 4'd12
    } op_idx_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU funct3 encodings (shared by OP and OP-IMM)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [NUM_OPS-1:0] op_en;
        logic [XLEN-1:0]    op_a;
        logic [XLEN-1:0]    op_b;
        logic [4:0]         rd;
        logic               wb_en;
        logic               is_branch;
        logic               br_inv;
        logic               illegal;
    } issue_t;

endpackage

// File: rtl/ex_op_decode.sv
// ex_op_decode: purely combinational RV32I ALU/branch/LUI/AUIPC decoder.
//   instr   : raw instruction
//   pc      : instruction address (AUIPC operand a)
//   rs1_val : rs1 register value
//   rs2_val : rs2 register value
//   dec     : decoded issue_t (one-hot op_en, operands, rd, flags)
module ex_op_decode
    import ex_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output issue_t          dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_field;
    logic       f7_zero;
    logic       f7_alt;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    assign opcode   = instr[6:0];
    assign rd_field = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign f7_zero  = (funct7 == F7_ZERO);
    assign f7_alt   = (funct7 == F7_ALT);
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_u    = {instr[31:12], 12'b0};
    assign shamt    = {27'b0, instr[24:20]};

    op_idx_e         op;
    logic            legal;
    logic            is_br;
    logic            inv;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        op    = OP_ADD;
        legal = 1'b0;
        is_br = 1'b0;
        inv   = 1'b0;
        a     = rs1_val;
        b     = rs2_val;

        case (opcode)
            OPC_OP: begin
                case (funct3)
                    F3_ADD:  begin legal = f7_zero | f7_alt; op = f7_alt ? OP_SUB : OP_ADD; end
                    F3_SLL:  begin legal = f7_zero; op = OP_SLL;  end
                    F3_SLT:  begin legal = f7_zero; op = OP_SLT;  end
                    F3_SLTU: begin legal = f7_zero; op = OP_SLTU; end
                    F3_XOR:  begin legal = f7_zero; op = OP_XOR;  end
                    F3_SRL:  begin legal = f7_zero | f7_alt; op = f7_alt ? OP_SRA : OP_SRL; end
                    F3_OR:   begin legal = f7_zero; op = OP_OR;   end
                    default: begin legal = f7_zero; op = OP_AND;  end
                endcase
            end
            OPC_OP_IMM: begin
                b = imm_i;
                case (funct3)
                    F3_ADD:  begin legal = 1'b1; op = OP_ADD;  end
                    F3_SLL:  begin legal = f7_zero; op = OP_SLL; b = shamt; end
                    F3_SLT:  begin legal = 1'b1; op = OP_SLT;  end
                    F3_SLTU: begin legal = 1'b1; op = OP_SLTU; end
                    F3_XOR:  begin legal = 1'b1; op = OP_XOR;  end
                    F3_SRL:  begin
                        legal = f7_zero | f7_alt;
                        op    = f7_alt ? OP_SRA : OP_SRL;
                        b     = shamt;
                    end
                    F3_OR:   begin legal = 1'b1; op = OP_OR;   end
                    default: begin legal = 1'b1; op = OP_AND;  end
                endcase
            end
            OPC_BRANCH: begin
                is_br = 1'b1;
                // Only eq/ge/geu compares exist; the other three branches invert them.
                case (funct3)
                    F3_BEQ:  begin legal = 1'b1; op = OP_EQ;              end
                    F3_BNE:  begin legal = 1'b1; op = OP_EQ;  inv = 1'b1; end
                    F3_BLT:  begin legal = 1'b1; op = OP_GE;  inv = 1'b1; end
                    F3_BGE:  begin legal = 1'b1; op = OP_GE;              end
                    F3_BLTU: begin legal = 1'b1; op = OP_GEU; inv = 1'b1; end
                    F3_BGEU: begin legal = 1'b1; op = OP_GEU;             end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                a     = '0;
                b     = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                a     = pc;
                b     = imm_u;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal encodings collapse to an all-zero payload with only the illegal flag set.
    always_comb begin
        dec = '0;
        if (legal) begin
            dec.op_en[op]  = 1'b1;
            dec.op_a       = a;
            dec.op_b       = b;
            // Branch rd field carries immediate bits, not a register.
            dec.rd         = is_br ? 5'd0 : rd_field;
            dec.wb_en      = !is_br && (rd_field != 5'd0);
            dec.is_branch  = is_br;
            dec.br_inv     = inv;
        end else begin
            dec.illegal    = 1'b1;
        end
    end

endmodule

// File: rtl/ex_op_issue.sv
// ex_op_issue: decode-to-execute issue stage with a 2-entry skid buffer.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop every held entry and the flush-cycle input
//   in_valid/in_ready : upstream handshake (in_ready is a flop output)
//   instr, pc, rs1_val, rs2_val : instruction and operands to decode
//   out_valid/out_ready : downstream handshake, 1 cycle accept-to-valid
//   op_en, op_a, op_b, rd, wb_en, is_branch, br_inv, illegal : issued entry
module ex_op_issue
    import ex_pkg::*;
#(
    parameter int XLEN_P    = XLEN,
    parameter int NUM_OPS_P = NUM_OPS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN_P-1:0]    instr,
    input  logic [XLEN_P-1:0]    pc,
    input  logic [XLEN_P-1:0]    rs1_val,
    input  logic [XLEN_P-1:0]    rs2_val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_OPS_P-1:0] op_en,
    output logic [XLEN_P-1:0]    op_a,
    output logic [XLEN_P-1:0]    op_b,
    output logic [4:0]           rd,
    output logic                 wb_en,
    output logic                 is_branch,
    output logic                 br_inv,
    output logic                 illegal
);

    issue_t dec;

    ex_op_decode u_decode (
        .instr   (instr),
        .pc      (pc),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .dec     (dec)
    );

    issue_t main_q, main_d;
    issue_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;

    logic accept;
    logic xfer;

    assign accept = in_valid && in_ready_q;
    assign xfer   = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            // Any transfer this cycle has already been consumed downstream; the input is dropped.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (xfer) begin
            if (skid_valid_q) begin
                // in_ready is low whenever skid is full, so no accept can collide here.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end
        end

        // Registered copy of !skid_valid so in_ready leaves this block straight from a flop.
        in_ready_d = !skid_valid_d;
    end

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload registers are reset as well, because the output fields must read zero after reset.
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign op_en     = main_q.op_en;
    assign op_a      = main_q.op_a;
    assign op_b      = main_q.op_b;
    assign rd        = main_q.rd;
    assign wb_en     = main_q.wb_en;
    assign is_branch = main_q.is_branch;
    assign br_inv    = main_q.br_inv;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_ex_op_issue.sv
// tb_ex_op_issue: directed stimulus with a scoreboard queue; a negedge
// monitor pops and compares every output transfer and checks that a
// stalled output holds still.
module tb_ex_op_issue;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, rs1_val, rs2_val, op_a, op_b;
    logic [12:0] op_en;
    logic [4:0]  rd;
    logic        wb_en, is_branch, br_inv, illegal;

    always #5 clk = ~clk;

    ex_op_issue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_en     (op_en),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd        (rd),
        .wb_en     (wb_en),
        .is_branch (is_branch),
        .br_inv    (br_inv),
        .illegal   (illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        issue_t      e;
    } vec_t;

    issue_t exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic issue_t mk(input logic [12:0] en, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] r, input logic wb, input logic br,
                                  input logic inv, input logic ill);
        issue_t t;
        t.op_en = en; t.op_a = a; t.op_b = b; t.rd = r;
        t.wb_en = wb; t.is_branch = br; t.br_inv = inv; t.illegal = ill;
        return t;
    endfunction

    function automatic issue_t cur_out();
        issue_t t;
        t.op_en = op_en; t.op_a = op_a; t.op_b = op_b; t.rd = rd;
        t.wb_en = wb_en; t.is_branch = is_branch; t.br_inv = br_inv; t.illegal = illegal;
        return t;
    endfunction

    // Monitor: compares each output transfer against the scoreboard head.
    issue_t held;
    logic   stalled = 1'b0;

    always @(negedge clk) begin
        issue_t c;
        issue_t e;
        c = cur_out();
        if (rst) begin
            stalled = 1'b0;
        end else if (out_valid) begin
            if (stalled)
                check("stall_hold", 96'(c), 96'(held));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 96'(c.op_a), 96'hX);
                end else begin
                    e = exp_q.pop_front();
                    check("op_en",     96'(c.op_en),     96'(e.op_en));
                    check("op_a",      96'(c.op_a),      96'(e.op_a));
                    check("op_b",      96'(c.op_b),      96'(e.op_b));
                    check("wb_en",     96'(c.wb_en),     96'(e.wb_en));
                    check("is_branch", 96'(c.is_branch), 96'(e.is_branch));
                    check("br_inv",    96'(c.br_inv),    96'(e.br_inv));
                    check("illegal",   96'(c.illegal),   96'(e.illegal));
                    if (!e.illegal && !e.is_branch)
                        check("rd", 96'(c.rd), 96'(e.rd));
                end
                stalled = 1'b0;
            end else begin
                held    = c;
                stalled = 1'b1;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // Present one instruction and hold it until accepted (bounded).
    task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input issue_t e);
        logic accepted;
        accepted = 1'b0;
        instr = i; pc = p; rs1_val = a; rs2_val = b; in_valid = 1'b1;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted)
            check("accept_timeout", 96'(accepted), 96'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && exp_q.size() != 0; n++)
            @(posedge clk);
        #1;
        check("drain_empty", 96'(exp_q.size()), 96'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, 96'(out_valid), 96'd0);
        check({tag, "_in_ready"},  96'(in_ready),  96'd1);
        check({tag, "_fields"},    96'(cur_out()), 96'd0);
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        // Input during reset must be ignored.
        in_valid = 1'b1; instr = 32'h002081B3; pc = 32'h100; rs1_val = 32'd5; rs2_val = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        check_reset_outputs("reset");
        @(posedge clk); #1;

        // Directed decode vectors, streamed back-to-back with out_ready=1.
        vecs.push_back('{32'h002081B3, 32'h100, 32'd5, 32'd7,        mk(13'h0001, 32'd5, 32'd7, 5'd3, 1, 0, 0, 0)}); // add x3
        vecs.push_back('{32'h40435293, 32'h100, 32'h80000000, 32'd7, mk(13'h0080, 32'h80000000, 32'd4, 5'd5, 1, 0, 0, 0)}); // srai
        vecs.push_back('{32'h02435293, 32'h100, 32'h80000000, 32'd7, mk(13'h0000, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1)}); // bad srai f7
        vecs.push_back('{32'h00209063, 32'h100, 32'd5, 32'd7,        mk(13'h0400, 32'd5, 32'd7, 5'd0, 0, 1, 1, 0)}); // bne
        vecs.push_back('{32'h123450B7, 32'h100, 32'd5, 32'd7,        mk(13'h0001, 32'd0, 32'h12345000, 5'd1, 1, 0, 0, 0)}); // lui
        vecs.push_back('{32'hFFF00093, 32'h100, 32'd9, 32'd7,        mk(13'h0001, 32'd9, 32'hFFFFFFFF, 5'd1, 1, 0, 0, 0)}); // addi -1
        vecs.push_back('{32'h00001117, 32'h100, 32'd5, 32'd7,        mk(13'h0001, 32'h100, 32'h1000, 5'd2, 1, 0, 0, 0)}); // auipc
        vecs.push_back('{32'h0020C063, 32'h100, 32'd5, 32'd7,        mk(13'h0800, 32'd5, 32'd7, 5'd0, 0, 1, 1, 0)}); // blt
        vecs.push_back('{32'h40208233, 32'h100, 32'd5, 32'd7,        mk(13'h0002, 32'd5, 32'd7, 5'd4, 1, 0, 0, 0)}); // sub x4
        vecs.push_back('{32'h00208033, 32'h100, 32'd5, 32'd7,        mk(13'h0001, 32'd5, 32'd7, 5'd0, 0, 0, 0, 0)}); // add x0
        vecs.push_back('{32'h022081B3, 32'h100, 32'd5, 32'd7,        mk(13'h0000, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1)}); // mul
        vecs.push_back('{32'h0020A063, 32'h100, 32'd5, 32'd7,        mk(13'h0000, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1)}); // branch f3=010
        vecs.push_back('{32'h0020B1B3, 32'h100, 32'd5, 32'd7,        mk(13'h0200, 32'd5, 32'd7, 5'd3, 1, 0, 0, 0)}); // sltu
        vecs.push_back('{32'h0000A083, 32'h100, 32'd5, 32'd7,        mk(13'h0000, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1)}); // load
        vecs.push_back('{32'h0020F063, 32'h100, 32'd5, 32'd7,        mk(13'h1000, 32'd5, 32'd7, 5'd0, 0, 1, 0, 0)}); // bgeu
        foreach (vecs[k]) begin
            v = vecs[k];
            send(v.instr, v.pc, v.rs1, v.rs2, v.e);
        end
        drain();

        // Stall: two entries fill main+skid, in_ready drops, then two more stream in.
        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'h11, 32'd1, mk(13'h0001, 32'h11, 32'd1, 5'd3, 1, 0, 0, 0));
        send(32'h002081B3, 32'h0, 32'h12, 32'd1, mk(13'h0001, 32'h12, 32'd1, 5'd3, 1, 0, 0, 0));
        @(negedge clk);
        check("stall_in_ready", 96'(in_ready), 96'd0);
        check("stall_out_valid", 96'(out_valid), 96'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h002081B3, 32'h0, 32'h13, 32'd1, mk(13'h0001, 32'h13, 32'd1, 5'd3, 1, 0, 0, 0));
        send(32'h002081B3, 32'h0, 32'h14, 32'd1, mk(13'h0001, 32'h14, 32'd1, 5'd3, 1, 0, 0, 0));
        drain();

        // Flush with both entries full and an input presented in the flush cycle.
        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'h21, 32'd2, mk(13'h0001, 32'h21, 32'd2, 5'd3, 1, 0, 0, 0));
        send(32'h002081B3, 32'h0, 32'h22, 32'd2, mk(13'h0001, 32'h22, 32'd2, 5'd3, 1, 0, 0, 0));
        instr = 32'h002081B3; rs1_val = 32'h99; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 96'(out_valid), 96'd0);
        check("flush_in_ready",  96'(in_ready),  96'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(32'h40208233, 32'h0, 32'h30, 32'd3, mk(13'h0002, 32'h30, 32'd3, 5'd4, 1, 0, 0, 0));
        drain();

        // Reset mid-stream with skid full.
        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'h41, 32'd4, mk(13'h0001, 32'h41, 32'd4, 5'd3, 1, 0, 0, 0));
        send(32'h002081B3, 32'h0, 32'h42, 32'd4, mk(13'h0001, 32'h42, 32'd4, 5'd3, 1, 0, 0, 0));
        instr = 32'h002081B3; rs1_val = 32'h77; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h00209063, 32'h0, 32'h50, 32'h50, mk(13'h0400, 32'h50, 32'h50, 5'd0, 0, 1, 1, 0));
        @(negedge clk);
        check("post_rst_latency", 96'(out_valid), 96'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_op_issue.md
Name: ex_op_issue

Overview:
Decode-to-execute issue stage. Accepts one RV32I instruction plus its register operands per cycle and decodes it into the one-hot ALU op-enable vector and operand pair consumed by the execute-stage op set. Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so throughput is full and in_ready is a register output. Sits between s2 decode/register-read and s3 execute.

Parameters:
XLEN, 32, operand/instruction width (only 32 supported)
NUM_OPS, 13, width of the op_en one-hot vector

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all held entries (branch mispredict/trap)
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept (registered)
instr  in  32  raw instruction
pc  in  32  instruction address
rs1_val  in  32  rs1 register value
rs2_val  in  32  rs2 register value
out_valid  out  1  issued op valid
out_ready  in  1  execute stage accepts
op_en  out  13  one-hot op select: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 eq, 11 ge, 12 geu
op_a  out  32  operand a
op_b  out  32  operand b
rd  out  5  destination register
wb_en  out  1  result written back (0 for branches, for rd=0, and for illegal)
is_branch  out  1  op is a conditional-branch compare
br_inv  out  1  invert compare result (bne/blt/bltu)
illegal  out  1  unrecognised encoding

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. On reset: out_valid=0, skid empty, op_en=0, op_a=op_b=0, rd=0, wb_en=is_branch=br_inv=illegal=0. in_ready reads 1 during and after reset. Inputs presented while rst=1 are ignored.
- Handshake: transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready. Latency 1 cycle from accept to out_valid. While out_valid&&!out_ready, all output fields are held stable. Order is strictly preserved.
- Skid buffer: main register plus one skid register.
  - in_ready=!skid_valid.
  - Accept while the output is stalled: the new entry goes to skid.
  - On an output transfer, skid moves to main.
  - Simultaneous input accept and output transfer with main occupied and skid empty: main is replaced in the same cycle (no bubble).
- Flush (priority over everything except rst): next cycle out_valid=0, skid empty, in_ready=1. An input presented in the flush cycle is dropped. An output transfer in the flush cycle still counts as consumed.
- Decode (combinational, registered on accept). Exactly one op_en bit is set unless illegal.
  - OP 0110011: funct3/funct7 select add/sub(f7=0100000)/sll/slt/sltu/xor/srl/sra(f7=0100000)/or/and; a=rs1_val, b=rs2_val. Any other f7 is illegal.
  - OP-IMM 0010011: same ops minus sub; b=sign-extended I-imm. slli/srli require f7=0000000; srai requires 0100000; for shifts b={27'b0,shamt}.
  - BRANCH 1100011: beq->eq, bne->eq+br_inv, blt->ge+br_inv, bge->ge, bltu->geu+br_inv, bgeu->geu; a=rs1_val, b=rs2_val; is_branch=1, wb_en=0. funct3 010/011 are illegal.
  - LUI 0110111: add, a=0, b={instr[31:12],12'b0}. AUIPC 0010111: add, a=pc, b=U-imm.
  - Everything else: illegal=1, op_en=0, wb_en=0, op_a=op_b=0. Illegal entries still flow through the handshake.
  - wb_en is forced to 0 when rd=0.

Decomposition:
- Package ex_pkg:
  - op index enum and NUM_OPS.
  - opcode/funct3/funct7 localparams.
  - packed struct issue_t {op_en, op_a, op_b, rd, wb_en, is_branch, br_inv, illegal} used for both the main and skid registers.
- Sub-module ex_op_decode: purely combinational, instr/pc/rs1_val/rs2_val -> issue_t. ex_op_issue holds the handshake, skid and flush logic only.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op_en=13'h0001, op_a=5, op_b=7, rd=3, wb_en=1.
- srai x5,x6,4 (0x40435293), rs1=0x80000000 -> op_en=13'h0080, op_b=4, rd=5. Same with f7=0000001 (0x02435293) -> illegal=1, op_en=0, wb_en=0.
- bne x1,x2 (0x00209063) -> op_en=13'h0400, is_branch=1, br_inv=1, wb_en=0. lui x1,0x12345 (0x123450B7) -> op_en=1, op_a=0, op_b=0x12345000.
- Stream of 4 back-to-back adds with out_ready=0 for cycles 2-4 -> in_ready falls after 2 held entries, outputs stable while stalled, all 4 emerge in order with no duplicate or loss.
- Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle instruction never appears.
- rst asserted mid-stream with a full skid -> next cycle all outputs at reset values, in_ready=1; a fresh accept then issues after 1 cycle.
